// File: rtl/bcd_counter_n_pkg.sv
`default_nettype none
// ============================================================================
// bcd_counter_n_pkg : digit constants and the digit sanitiser shared by the counter
// Revision: 1.0
// ============================================================================
package bcd_counter_n_pkg;

  localparam int              DIGIT_W = 4;
  localparam logic [3:0]      BCD_MAX = 4'd9;

  // Any non-decimal nibble reads as 9.
  function automatic logic [DIGIT_W-1:0] sanitise_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter_n_if.sv
`default_nettype none
// ============================================================================
// bcd_counter_n_if : control, load/limit and count signals of the BCD counter
// Revision: 1.0
// ============================================================================
interface bcd_counter_n_if #(
  parameter int DIGITS = 4
);
  import bcd_counter_n_pkg::*;

  logic                        en;
  logic                        up;
  logic                        clr_n;
  logic                        ld_n;
  logic [DIGIT_W*DIGITS-1:0]   data;
  logic [DIGIT_W*DIGITS-1:0]   limit;
  logic [DIGIT_W*DIGITS-1:0]   q;
  logic                        cn;
  logic                        wrapped;

  modport master (
    output en, up, clr_n, ld_n, data, limit,
    input  q, cn, wrapped
  );

  modport slave (
    input  en, up, clr_n, ld_n, data, limit,
    output q, cn, wrapped
  );

endinterface
`default_nettype wire

// File: rtl/bcd_counter_n_digit.sv
`default_nettype none
// ============================================================================
// bcd_digit : one BCD digit register with load, increment and decrement strobes
// Revision: 1.0
// ============================================================================
module bcd_digit
  import bcd_counter_n_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry,
  output logic               borrow
);

  logic [DIGIT_W-1:0] r_digit;

  assign digit  = r_digit;
  assign carry  = inc & (r_digit == BCD_MAX);
  assign borrow = dec & (r_digit == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (ld) begin
      r_digit <= ld_val;
    end else if (inc) begin
      r_digit <= (r_digit == BCD_MAX) ? '0 : r_digit + 4'd1;
    end else if (dec) begin
      r_digit <= (r_digit == '0) ? BCD_MAX : r_digit - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
// bcd_counter_n : N-digit up/down BCD counter with programmable terminal value
// Revision: 1.0
// ============================================================================
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_counter_n_if.slave   bus
);

  localparam int W = DIGIT_W * DIGITS;

  logic [W-1:0]    w_limit_s;
  logic [W-1:0]    w_data_s;
  logic [W-1:0]    w_q;
  logic [W-1:0]    w_ld_val;
  logic [DIGITS:0] w_carry;
  logic [DIGITS:0] w_borrow;
  logic            w_active;
  logic            w_at_top;
  logic            w_at_zero;
  logic            w_wrap_cond;
  logic            w_wrap;
  logic            w_step;
  logic            w_ld;
  logic            w_ripple_out;
  logic            r_wrapped;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_sanitise
      assign w_limit_s[gi*DIGIT_W +: DIGIT_W] = sanitise_digit(bus.limit[gi*DIGIT_W +: DIGIT_W]);
      assign w_data_s[gi*DIGIT_W +: DIGIT_W]  = sanitise_digit(bus.data[gi*DIGIT_W +: DIGIT_W]);
    end
  endgenerate

  assign w_active    = bus.en & bus.clr_n & bus.ld_n;
  assign w_at_top    = (w_q >= w_limit_s);
  assign w_at_zero   = (w_q == '0);
  assign w_wrap_cond = bus.up ? w_at_top : w_at_zero;
  assign w_wrap      = w_active & w_wrap_cond;
  assign w_step      = w_active & ~w_wrap_cond;

  assign w_carry[0]  = w_step & bus.up;
  assign w_borrow[0] = w_step & ~bus.up;

  // Clear, load and wrap all go through the digits' parallel-load path.
  assign w_ld = ~bus.clr_n | ~bus.ld_n | w_wrap;

  always_comb begin
    w_ld_val = '0;
    if (!bus.clr_n) begin
      w_ld_val = '0;
    end else if (!bus.ld_n) begin
      w_ld_val = w_data_s;
    end else if (!bus.up) begin
      w_ld_val = w_limit_s;
    end
  end

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (w_ld),
        .ld_val (w_ld_val[gi*DIGIT_W +: DIGIT_W]),
        .inc    (w_carry[gi]),
        .dec    (w_borrow[gi]),
        .digit  (w_q[gi*DIGIT_W +: DIGIT_W]),
        .carry  (w_carry[gi+1]),
        .borrow (w_borrow[gi+1])
      );
    end
  endgenerate

  // A ripple out of the top digit would also be a wrap; the limit compare
  // normally pre-empts it, so this only matters as a safety net.
  assign w_ripple_out = w_carry[DIGITS] | w_borrow[DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrapped <= 1'b0;
    end else if (!bus.clr_n) begin
      r_wrapped <= 1'b0;
    end else if (bus.ld_n && (w_wrap || w_ripple_out)) begin
      r_wrapped <= 1'b1;
    end
  end

  assign bus.q       = w_q;
  assign bus.cn      = w_wrap;
  assign bus.wrapped = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
`default_nettype none
// Directed self-checking bench for bcd_counter_n with a 2-digit and a 4-digit instance.
module tb_bcd_counter_n;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  int   fails;

  bcd_counter_n_if #(.DIGITS(2)) a2 ();
  bcd_counter_n_if #(.DIGITS(4)) a4 ();

  bcd_counter_n #(.DIGITS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(a2.slave));
  bcd_counter_n #(.DIGITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(a4.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] bcd2(input int k);
    logic [15:0] v;
    v = 16'(((k / 10) << 4) | (k % 10));
    return v;
  endfunction

  initial begin
    checks = 0; passes = 0; fails = 0;
    rst_n = 1'b1;
    a2.en = 1'b0; a2.up = 1'b1; a2.clr_n = 1'b1; a2.ld_n = 1'b1; a2.data = '0; a2.limit = 8'h59;
    a4.en = 1'b0; a4.up = 1'b1; a4.clr_n = 1'b1; a4.ld_n = 1'b1; a4.data = '0; a4.limit = 16'h9999;
    #1 rst_n = 1'b0;
    #2;
    check("rst_q2", 16'(a2.q), 16'h0000);
    check("rst_wrapped2", 16'(a2.wrapped), 16'h0000);
    check("rst_q4", a4.q, 16'h0000);
    #9 rst_n = 1'b1;
    a2.en = 1'b1;
    #1;

    // Modulo-60 up count
    for (int k = 0; k < 60; k++) begin
      check("up60_q", 16'(a2.q), bcd2(k));
      check("up60_cn", 16'(a2.cn), 16'(k == 59));
      if (k < 59) tick();
    end
    tick();
    check("up60_wrap_q", 16'(a2.q), 16'h0000);
    check("up60_wrapped", 16'(a2.wrapped), 16'h0001);
    check("up60_cn_after", 16'(a2.cn), 16'h0000);

    a2.clr_n = 1'b0; #1;
    check("clr_cn", 16'(a2.cn), 16'h0000);
    tick();
    check("clr_q", 16'(a2.q), 16'h0000);
    check("clr_wrapped", 16'(a2.wrapped), 16'h0000);
    a2.clr_n = 1'b1;

    // Down count from 00 with limit 23
    a2.up = 1'b0; a2.limit = 8'h23; #1;
    check("dn_cn_at0", 16'(a2.cn), 16'h0001);
    tick();
    check("dn_wrap_q", 16'(a2.q), 16'h0023);
    check("dn_wrapped", 16'(a2.wrapped), 16'h0001);
    tick();
    check("dn_q22", 16'(a2.q), 16'h0022);
    tick();
    check("dn_q21", 16'(a2.q), 16'h0021);

    // Clear beats load
    a2.clr_n = 1'b0; a2.ld_n = 1'b0; a2.data = 8'h45;
    tick();
    check("clrld_q", 16'(a2.q), 16'h0000);
    check("clrld_wrapped", 16'(a2.wrapped), 16'h0000);
    a2.clr_n = 1'b1;

    // Load with sanitising, then count up
    a2.data = 8'hF7; #1;
    check("ld_cn", 16'(a2.cn), 16'h0000);
    tick();
    check("ld_q97", 16'(a2.q), 16'h0097);
    check("ld_wrapped", 16'(a2.wrapped), 16'h0000);
    a2.ld_n = 1'b1; a2.up = 1'b1; a2.limit = 8'h99;
    tick();
    check("up_q98", 16'(a2.q), 16'h0098);

    // Sanitised limit FA reads as 99
    a2.limit = 8'hFA; #1;
    check("lim_fa_cn98", 16'(a2.cn), 16'h0000);
    tick();
    check("lim_fa_q99", 16'(a2.q), 16'h0099);
    check("lim_fa_cn99", 16'(a2.cn), 16'h0001);
    tick();
    check("lim_fa_wrap", 16'(a2.q), 16'h0000);
    check("lim_fa_wrapped", 16'(a2.wrapped), 16'h0001);

    // Down from above the limit: no clamp
    a2.ld_n = 1'b0; a2.data = 8'h80;
    tick();
    check("ld80_q", 16'(a2.q), 16'h0080);
    check("ld_keeps_wrapped", 16'(a2.wrapped), 16'h0001);
    a2.ld_n = 1'b1; a2.up = 1'b0; a2.limit = 8'h23;
    tick();
    check("noclamp_q79", 16'(a2.q), 16'h0079);
    check("noclamp_cn", 16'(a2.cn), 16'h0000);

    // Direction toggle, then q above limit wraps up
    a2.up = 1'b1; a2.limit = 8'h99;
    tick();
    check("toggle_q80", 16'(a2.q), 16'h0080);
    a2.limit = 8'h50; #1;
    check("above_lim_cn", 16'(a2.cn), 16'h0001);
    tick();
    check("above_lim_q", 16'(a2.q), 16'h0000);

    // Hold
    a2.ld_n = 1'b0; a2.data = 8'h12;
    tick();
    a2.ld_n = 1'b1; a2.en = 1'b0; #1;
    check("hold_cn", 16'(a2.cn), 16'h0000);
    tick();
    check("hold_q", 16'(a2.q), 16'h0012);

    // Asynchronous reset between edges
    a2.ld_n = 1'b0; a2.data = 8'h37;
    tick();
    check("pre_rst_q37", 16'(a2.q), 16'h0037);
    a2.ld_n = 1'b1; a2.en = 1'b1; a2.up = 1'b1; a2.limit = 8'h99;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_q", 16'(a2.q), 16'h0000);
    check("async_rst_wrapped", 16'(a2.wrapped), 16'h0000);
    #1 rst_n = 1'b1;
    tick();
    check("resume_q01", 16'(a2.q), 16'h0001);

    // Four-digit full ripple
    a4.ld_n = 1'b0; a4.data = 16'h0999;
    tick();
    check("d4_ld", a4.q, 16'h0999);
    a4.ld_n = 1'b1; a4.en = 1'b1; a4.up = 1'b1;
    tick();
    check("d4_ripple_up", a4.q, 16'h1000);
    a4.up = 1'b0;
    tick();
    check("d4_ripple_dn", a4.q, 16'h0999);
    a4.ld_n = 1'b0; a4.data = 16'h0000;
    tick();
    a4.ld_n = 1'b1; #1;
    check("d4_cn_zero", 16'(a4.cn), 16'h0001);
    tick();
    check("d4_wrap_dn", a4.q, 16'h9999);
    check("d4_wrapped", 16'(a4.wrapped), 16'h0001);
    a4.up = 1'b1; #1;
    check("d4_cn_top", 16'(a4.cn), 16'h0001);
    tick();
    check("d4_wrap_up", a4.q, 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of BCD digits (legal range 1..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port en  input  1  count enable.
REQ-005 SHALL have port up  input  1  direction: 1 counts up, 0 counts down.
REQ-006 SHALL have port clr_n  input  1  synchronous active-low clear.
REQ-007 SHALL have port ld_n  input  1  synchronous active-low load.
REQ-008 SHALL have port data  input  4*DIGITS  load value, digit 0 in bits [3:0].
REQ-009 SHALL have port limit  input  4*DIGITS  terminal value (modulus minus 1).
REQ-010 SHALL have port q  output  4*DIGITS  registered BCD count.
REQ-011 SHALL have port cn  output  1  combinational carry/borrow for cascading.
REQ-012 SHALL have port wrapped  output  1  registered sticky flag, set on any wrap.

Function
REQ-013 Each rising clk edge SHALL apply exactly one action, in priority clr_n=0 > ld_n=0 > en=1 > hold.
REQ-014 clr_n=0 SHALL set q to 0 and wrapped to 0.
REQ-015 ld_n=0 SHALL set q to data, with every digit greater than 9 replaced by 9; wrapped is unchanged.
REQ-016 Before any comparison, limit SHALL be sanitised per digit in the same way (a digit greater than 9 reads as 9).
REQ-017 Up count SHALL apply when en=1 and up=1.
REQ-017a Up count: if q >= limit (packed-vector compare), q SHALL become 0 and wrapped SHALL be set to 1.
REQ-017b Up count: otherwise q SHALL take its decimal increment, where a digit at 9 becomes 0 and carries into the next digit.
REQ-018 Down count SHALL apply when en=1 and up=0.
REQ-018a Down count: if q == 0, q SHALL become the sanitised limit and wrapped SHALL be set to 1.
REQ-018b Down count: otherwise q SHALL take its decimal decrement, where a digit at 0 becomes 9 and borrows from the next digit.
REQ-018c Down count from q > limit SHALL continue decrementing normally with no clamp.
REQ-019 cn SHALL equal en & clr_n & ld_n & (up ? (q >= limit) : (q == 0)), driven combinationally in the same cycle.
REQ-020 Latency from any control input to q SHALL be 1 clk; cn SHALL have zero latency.
REQ-021 A change of limit SHALL take effect on the next edge with no pipeline.
REQ-022 With limit = all-9s, the block SHALL behave as a free-running 10^DIGITS counter.
REQ-023 Toggling up while en=1 SHALL count in the new direction on the very next edge.

Reset
REQ-024 rst_n=0 SHALL force q=0 and wrapped=0 immediately, regardless of clk.
REQ-025 rst_n=0 SHALL force cn=0 through its dependence on q and the control inputs only when en=0 or up=1 with q < limit; otherwise cn follows REQ-019.
REQ-026 On rst_n deassertion, the first active edge SHALL obey REQ-013.
REQ-027 Reset asserted mid-count SHALL discard the count with no partial digit update.

Structure
REQ-028 A shared package SHALL hold BCD_MAX=4'd9, the digit width 4, and a sanitise-digit function.
REQ-029 The block SHALL contain one sub-module, bcd_digit, instantiated DIGITS times.
REQ-029a bcd_digit SHALL take inc and dec strobes and return a ripple carry and a ripple borrow.
REQ-029b The top level SHALL own the limit compare, the wrap mux, and the wrapped flag.

Verification
REQ-030 DIGITS=2, limit=59, up=1, en=1 from 0 -> q steps 00..59; cn=1 only at 59; next edge q=00 and wrapped=1.
REQ-031 DIGITS=2, limit=23, up=0 from q=00 -> cn=1; next edge q=23, then 22, 21.
REQ-032 ld_n=0 with data=8'hF7 -> q=8'h97; the following up count with limit=99 gives 98.
REQ-033 clr_n=0 and ld_n=0 together with en=1 -> q=0 and wrapped=0 (clear wins).
REQ-034 DIGITS=4, limit=9999, q=0999, up count -> q=1000 in one edge (full ripple).
REQ-035 rst_n pulsed low between edges while q=37 -> q=0 and wrapped=0 asynchronously; counting resumes from 0.
